// File: rtl/fifo_pkt_writer.sv
// fifo_pkt_writer: write-side packet framer for the dual-clock FIFO.
// Buffers one packet from a valid/ready/last stream, then writes a length
// header (word count - 1) followed by the payload into the FIFO, honouring
// the FIFO's full flag.
// Ports: wr_clk/rst_n (async, active-low); s_valid/s_ready/s_data/s_last
// upstream stream; full/wr_en/data_in FIFO write side; busy, pkt_sent,
// err_trunc status strobes; trunc_cnt saturating truncated-packet count.
// Build option: define CHK_TRAILER_EN to append an XOR check trailer word.
module fifo_pkt_writer #(
    parameter int DATA_WIDTH = 6,
    parameter int MAX_PKT    = 8
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  pkt_sent,
    output logic                  err_trunc,
    output logic [7:0]            trunc_cnt
);

    localparam int CW = $clog2(MAX_PKT) + 1;
    localparam int IW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;

    typedef enum logic [2:0] {
        S_COLLECT,
        S_DISCARD,
        S_HEADER,
`ifdef CHK_TRAILER_EN
        S_TRAILER,
`endif
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_idx;
    logic [7:0]            r_trunc_cnt;
    logic [DATA_WIDTH-1:0] r_buf [MAX_PKT];

    logic                  w_accept;
    logic                  w_last_word;
    logic [CW-1:0]         w_cnt_m1;
    logic [DATA_WIDTH-1:0] w_hdr;

`ifdef CHK_TRAILER_EN
    logic [DATA_WIDTH-1:0] r_xor;
`endif

    assign w_cnt_m1    = r_cnt - CW'(1);
    assign w_hdr       = DATA_WIDTH'(w_cnt_m1);
    assign w_last_word = (r_idx == w_cnt_m1);
    assign trunc_cnt   = r_trunc_cnt;

    // Outputs are decoded straight from state so the FIFO captures data_in
    // on the same edge that wr_en is seen; rst_n gates the handshakes.
    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        wr_en        = 1'b0;
        data_in      = '0;
        busy         = 1'b0;
        pkt_sent     = 1'b0;
        err_trunc    = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            S_COLLECT: begin
                s_ready  = rst_n;
                w_accept = s_valid && s_ready;
                if (w_accept) begin
                    if (s_last)
                        w_next_state = S_HEADER;
                    else if (r_cnt == CW'(MAX_PKT - 1))
                        w_next_state = S_DISCARD;
                end
            end
            S_DISCARD: begin
                s_ready  = rst_n;
                w_accept = s_valid && s_ready;
                if (w_accept && s_last) begin
                    w_next_state = S_HEADER;
                    err_trunc    = 1'b1;
                end
            end
            S_HEADER: begin
                busy    = rst_n;
                wr_en   = rst_n && !full;
                data_in = w_hdr;
                if (wr_en)
                    w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                busy    = rst_n;
                wr_en   = rst_n && !full;
                data_in = r_buf[r_idx[IW-1:0]];
                if (wr_en && w_last_word) begin
`ifdef CHK_TRAILER_EN
                    w_next_state = S_TRAILER;
`else
                    w_next_state = S_COLLECT;
                    pkt_sent     = 1'b1;
`endif
                end
            end
`ifdef CHK_TRAILER_EN
            S_TRAILER: begin
                busy    = rst_n;
                wr_en   = rst_n && !full;
                data_in = r_xor;
                if (wr_en) begin
                    w_next_state = S_COLLECT;
                    pkt_sent     = 1'b1;
                end
            end
`endif
            default: w_next_state = S_COLLECT;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_COLLECT;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_trunc_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_COLLECT && w_accept)
                r_cnt <= r_cnt + CW'(1);
            if (err_trunc && r_trunc_cnt != 8'hFF)
                r_trunc_cnt <= r_trunc_cnt + 8'd1;
            if (r_state == S_HEADER && wr_en)
                r_idx <= '0;
            if (r_state == S_DRAIN && wr_en) begin
                r_idx <= r_idx + CW'(1);
                if (w_last_word)
                    r_cnt <= '0;
            end
        end
    end

    // Payload storage needs no reset: cnt/idx guard every read.
    always_ff @(posedge wr_clk) begin
        if (r_state == S_COLLECT && w_accept)
            r_buf[r_cnt[IW-1:0]] <= s_data;
    end

`ifdef CHK_TRAILER_EN
    // Running XOR of every word written for the packet (header included).
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n)
            r_xor <= '0;
        else if (r_state == S_COLLECT)
            r_xor <= '0;
        else if (wr_en)
            r_xor <= r_xor ^ data_in;
    end
`endif

endmodule

// File: doc/fifo_pkt_writer.md
Name: fifo_pkt_writer

Overview:
Write-side producer for the dual-clock FIFO, in the wr_clk domain. It accepts a framed word stream (valid/ready/last) from upstream logic and buffers one whole packet locally. It then writes a length header word followed by the payload into the FIFO, obeying FULL, so the rd_clk-side consumer always sees the length before the data.

Parameters:
DATA_WIDTH, 6, word width; matches FIFO data width.
MAX_PKT, 8, maximum payload words per packet; legal range 1..2**DATA_WIDTH.

Ports:
wr_clk  input  1  write-domain clock; all logic on posedge.
rst_n  input  1  asynchronous, active-low reset.
s_valid  input  1  upstream word valid.
s_ready  output  1  upstream word accepted when s_valid && s_ready.
s_data  input  DATA_WIDTH  upstream payload word.
s_last  input  1  marks final word of packet.
full  input  1  FIFO FULL flag (wr_clk domain).
wr_en  output  1  FIFO write enable.
data_in  output  DATA_WIDTH  FIFO write data.
busy  output  1  high in HEADER/DRAIN/TRAILER.
pkt_sent  output  1  1-cycle pulse on the final FIFO write of a packet.
err_trunc  output  1  1-cycle pulse when a truncated packet's s_last is consumed.
trunc_cnt  output  8  saturating count of truncated packets.

Behaviour:
- Reset (async, rst_n low): state=COLLECT, cnt=0, idx=0, trunc_cnt=0, pkt_sent=0, err_trunc=0. s_ready, wr_en and busy are forced to 0 while rst_n is low.
- Buffer: MAX_PKT x DATA_WIDTH registers. cnt is the stored word count, clog2(MAX_PKT)+1 bits.
- COLLECT: s_ready=1.
  - On accept: buf[cnt]<=s_data, cnt++.
  - Accept with s_last -> HEADER.
  - Accept without s_last that makes cnt==MAX_PKT -> DISCARD.
- DISCARD: s_ready=1. Accepted words are dropped. Accept with s_last -> HEADER, err_trunc pulses that cycle, trunc_cnt++ saturating at 255.
- HEADER: s_ready=0. wr_en = !full. data_in = cnt-1, zero-extended/truncated to DATA_WIDTH. When wr_en: idx<=0 -> DRAIN.
- DRAIN: s_ready=0. wr_en = !full. data_in = buf[idx].
  - On write: idx++.
  - Write with idx==cnt-1 -> COLLECT (or TRAILER when CHK_TRAILER_EN), cnt<=0, pkt_sent pulses that cycle when no trailer.
- wr_en and data_in are combinational from state, idx and full. There are no registered copies. The FIFO captures on the same wr_clk edge. full never creates a comb loop because FIFO FULL is derived from registers only.
- full high stalls the current word indefinitely: data_in is held and idx is unchanged. There is no write while full=1.
- The minimum packet of 1 word writes header 0 then 1 payload word.
- Latency: header write is earliest on the cycle after s_last is accepted. An N-word packet with full=0 takes N+1 consecutive wr_en cycles.
- Back-to-back packets: s_ready returns 1 on the cycle after the last FIFO write. There is no overlap of collect and drain.
- s_valid while s_ready=0 is ignored; upstream must hold its data.
- Reset mid-packet: a partial packet is discarded entirely. Any words already written to the FIFO remain there; the system resets the FIFO together with this block.

Optional Feature:
Macro CHK_TRAILER_EN.
- Defined: after DRAIN, state TRAILER writes one extra word, the XOR of the header and all payload words. The XOR accumulator clears in COLLECT and updates on each FIFO write. TRAILER has wr_en=!full. pkt_sent pulses on the trailer write, then the block returns to COLLECT. An N-word packet occupies N+2 FIFO entries.
- Undefined: TRAILER state and the accumulator are absent. pkt_sent pulses on the last payload write.

Test Plan:
1. Reset, then a 3-word packet 0x11,0x05,0x2A (last on 0x2A), full=0 -> wr_en high 4 consecutive cycles, data_in 0x02,0x11,0x05,0x2A; pkt_sent on the 4th; s_ready=0 during those cycles.
2. 1-word packet 0x3F -> writes 0x00,0x3F; s_ready high again on the cycle after.
3. full=1 held for 5 cycles during DRAIN at idx=1 -> wr_en=0 for 5 cycles, data_in stable at buf[1]; after full falls, the remaining words are written in order with none lost or duplicated.
4. 11-word packet with MAX_PKT=8 -> header 0x07 plus the first 8 words written; words 9-11 dropped; err_trunc single pulse; trunc_cnt=1.
5. rst_n low after 2 words collected -> wr_en=0 and s_ready=0 during reset; after release, a fresh 2-word packet 0x01,0x02 writes 0x01,0x01,0x02.
6. With CHK_TRAILER_EN, packet 0x11,0x05,0x2A -> writes 0x02,0x11,0x05,0x2A, then trailer 0x02^0x11^0x05^0x2A=0x3C; pkt_sent on the trailer write.
